alu_cmd_sequencer: RTL and testbench

//  Upstream command stage for the registered ALU_TOP datapath. Accepts one
//  {A, B, ALU_FUN} request over a valid/ready handshake and drives the

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_result_mux.sv | 50 +++++
 rtl/alu_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU_FUN opcodes, result-unit select codes and the
// command sequencer FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_NAND  = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_NOP   = 4'b1000;
  localparam logic [3:0] OP_EQ    = 4'b1001;
  localparam logic [3:0] OP_GT    = 4'b1010;
  localparam logic [3:0] OP_LT    = 4'b1011;
  localparam logic [3:0] OP_SHR_A = 4'b1100;
  localparam logic [3:0] OP_SHL_A = 4'b1101;
  localparam logic [3:0] OP_SHR_B = 4'b1110;
  localparam logic [3:0] OP_SHL_B = 4'b1111;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_t;

endpackage

// File: rtl/alu_result_mux.sv
// Selects the result, flag and carry of one ALU unit using the unit field
// (ALU_FUN[3:2]) of the issued opcode.
module alu_result_mux
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       unit_sel,
  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             carry_in,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic [WIDTH-1:0] sel_data,
  output logic             sel_flag,
  output logic             sel_carry
);

  // Carry is only meaningful for the arithmetic unit; other units report 0.
  always_comb begin
    sel_data  = '0;
    sel_flag  = 1'b0;
    sel_carry = 1'b0;
    case (unit_sel_t'(unit_sel))
      UNIT_ARITH: begin
        sel_data  = arith_out;
        sel_flag  = arith_flag;
        sel_carry = carry_in;
      end
      UNIT_LOGIC: begin
        sel_data = logic_out;
        sel_flag = logic_flag;
      end
      UNIT_CMP: begin
        sel_data = cmp_out;
        sel_flag = cmp_flag;
      end
      UNIT_SHIFT: begin
        sel_data = shift_out;
        sel_flag = shift_flag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command stage in front of the registered ALU: accepts one request, waits out
// the ALU latency, then returns the selected unit's result over valid/ready.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_fun,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fun,
  input  logic [WIDTH-1:0] alu_arith_out,
  input  logic [WIDTH-1:0] alu_logic_out,
  input  logic [WIDTH-1:0] alu_cmp_out,
  input  logic [WIDTH-1:0] alu_shift_out,
  input  logic             alu_carry_out,
  input  logic             alu_arith_flag,
  input  logic             alu_logic_flag,
  input  logic             alu_cmp_flag,
  input  logic             alu_shift_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_fun_q, alu_fun_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, cmd_ready_d;

  logic [WIDTH-1:0] sel_data;
  logic             sel_flag;
  logic             sel_carry;

  alu_result_mux #(.WIDTH(WIDTH)) u_result_mux (
    .unit_sel   (alu_fun_q[3:2]),
    .arith_out  (alu_arith_out),
    .logic_out  (alu_logic_out),
    .cmp_out    (alu_cmp_out),
    .shift_out  (alu_shift_out),
    .carry_in   (alu_carry_out),
    .arith_flag (alu_arith_flag),
    .logic_flag (alu_logic_flag),
    .cmp_flag   (alu_cmp_flag),
    .shift_flag (alu_shift_flag),
    .sel_data   (sel_data),
    .sel_flag   (sel_flag),
    .sel_carry  (sel_carry)
  );

  // Divide-by-zero is answered directly from IDLE without touching the ALU.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          alu_fun_d = cmd_fun;
          if (cmd_fun == OP_DIV && cmd_b == '0) begin
            rsp_data_d  = '0;
            rsp_carry_d = 1'b0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(ALU_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = sel_data;
          rsp_carry_d = sel_carry;
          rsp_err_d   = ~sel_flag;
          rsp_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // cmd_ready is registered so it reads 0 while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= OP_NOP;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fun   = alu_fun_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_valid = rsp_valid_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer driving a small registered ALU stand-in
// (one-cycle latency, one-hot unit flags).
module tb_alu_cmd_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic [3:0]       cmd_fun = '0;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_fun;
  logic [WIDTH-1:0] alu_arith_out, alu_logic_out, alu_cmp_out, alu_shift_out;
  logic             alu_carry_out;
  logic             alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry, rsp_err, busy;

  int num_checks = 0;
  int num_fail   = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .ALU_LAT(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_a          (cmd_a),
    .cmd_b          (cmd_b),
    .cmd_fun        (cmd_fun),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_fun        (alu_fun),
    .alu_arith_out  (alu_arith_out),
    .alu_logic_out  (alu_logic_out),
    .alu_cmp_out    (alu_cmp_out),
    .alu_shift_out  (alu_shift_out),
    .alu_carry_out  (alu_carry_out),
    .alu_arith_flag (alu_arith_flag),
    .alu_logic_flag (alu_logic_flag),
    .alu_cmp_flag   (alu_cmp_flag),
    .alu_shift_flag (alu_shift_flag),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_carry      (rsp_carry),
    .rsp_err        (rsp_err),
    .busy           (busy)
  );

  // Registered ALU stand-in: every unit computes, only the selected one flags.
  logic [16:0]      m_sum;
  logic [WIDTH-1:0] m_arith, m_logic, m_cmp, m_shift;
  logic             m_carry;

  always_comb begin
    m_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    m_arith = '0;
    m_carry = 1'b0;
    case (alu_fun[1:0])
      2'b00: begin m_arith = m_sum[15:0]; m_carry = m_sum[16]; end
      2'b01: m_arith = alu_a - alu_b;
      2'b10: m_arith = alu_a * alu_b;
      default: m_arith = (alu_b == '0) ? '0 : alu_a / alu_b;
    endcase
    case (alu_fun[1:0])
      2'b00: m_logic = alu_a & alu_b;
      2'b01: m_logic = alu_a | alu_b;
      2'b10: m_logic = ~(alu_a & alu_b);
      default: m_logic = ~(alu_a | alu_b);
    endcase
    case (alu_fun[1:0])
      2'b00: m_cmp = '0;
      2'b01: m_cmp = (alu_a == alu_b) ? 16'd1 : 16'd0;
      2'b10: m_cmp = (alu_a > alu_b) ? 16'd2 : 16'd0;
      default: m_cmp = (alu_a < alu_b) ? 16'd3 : 16'd0;
    endcase
    case (alu_fun[1:0])
      2'b00: m_shift = alu_a >> 1;
      2'b01: m_shift = alu_a << 1;
      2'b10: m_shift = alu_b >> 1;
      default: m_shift = alu_b << 1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_arith_out  <= '0;
      alu_logic_out  <= '0;
      alu_cmp_out    <= '0;
      alu_shift_out  <= '0;
      alu_carry_out  <= 1'b0;
      alu_arith_flag <= 1'b0;
      alu_logic_flag <= 1'b0;
      alu_cmp_flag   <= 1'b0;
      alu_shift_flag <= 1'b0;
    end else begin
      alu_arith_out  <= m_arith;
      alu_logic_out  <= m_logic;
      alu_cmp_out    <= m_cmp;
      alu_shift_out  <= m_shift;
      alu_carry_out  <= m_carry;
      alu_arith_flag <= (alu_fun[3:2] == 2'b00);
      alu_logic_flag <= (alu_fun[3:2] == 2'b01);
      alu_cmp_flag   <= (alu_fun[3:2] == 2'b10);
      alu_shift_flag <= (alu_fun[3:2] == 2'b11);
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents a command at a negedge and returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] fun);
    bit accepted = 1'b0;
    @(negedge clk);
    cmd_a     = a;
    cmd_b     = b;
    cmd_fun   = fun;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) checkOutput("accept_timeout", 16'd0, 16'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts clock edges after the accept edge until rsp_valid is seen.
  task automatic waitResponse(output int edges);
    bit seen = 1'b0;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
    if (!seen) checkOutput("rsp_timeout", 16'd0, 16'd1);
  endtask

  task automatic finishResponse(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 16'(rsp_valid), 16'd0);
    checkOutput({tag, "_ready_back"}, 16'(cmd_ready), 16'd1);
  endtask

  task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] fun, input logic [15:0] exp_data,
                       input logic exp_carry, input logic exp_err, input int exp_edges);
    int edges;
    applyStimulus(a, b, fun);
    waitResponse(edges);
    checkOutput({tag, "_latency"}, 16'(edges), 16'(exp_edges));
    checkOutput({tag, "_data"}, rsp_data, exp_data);
    checkOutput({tag, "_carry"}, 16'(rsp_carry), 16'(exp_carry));
    checkOutput({tag, "_err"}, 16'(rsp_err), 16'(exp_err));
    checkOutput({tag, "_alu_fun"}, 16'(alu_fun), 16'(fun));
    finishResponse(tag);
  endtask

  initial begin
    int  edges;
    bit  ghost;

    #12;
    checkOutput("rst_valid", 16'(rsp_valid), 16'd0);
    checkOutput("rst_ready", 16'(cmd_ready), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_alu_fun", 16'(alu_fun), 16'h0008);
    checkOutput("rst_data", rsp_data, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 16'(cmd_ready), 16'd1);
    checkOutput("post_rst_busy", 16'(busy), 16'd0);

    runOp("add",   16'd5,     16'd2, 4'b0000, 16'd7,     1'b0, 1'b0, 2);
    runOp("carry", 16'hFFFF,  16'd1, 4'b0000, 16'd0,     1'b1, 1'b0, 2);
    runOp("nand",  16'd5,     16'd2, 4'b0110, 16'hFFFF,  1'b0, 1'b0, 2);
    runOp("gt",    16'd5,     16'd2, 4'b1010, 16'd2,     1'b0, 1'b0, 2);
    runOp("shl_a", 16'd5,     16'd2, 4'b1101, 16'd10,    1'b0, 1'b0, 2);
    runOp("div0",  16'd5,     16'd0, 4'b0011, 16'd0,     1'b0, 1'b1, 0);
    runOp("div",   16'd9,     16'd3, 4'b0011, 16'd3,     1'b0, 1'b0, 2);

    // Backpressure: response must hold while rsp_ready stays low.
    applyStimulus(16'd5, 16'd2, 4'b0001);
    waitResponse(edges);
    checkOutput("bp_latency", 16'(edges), 16'd2);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_data", rsp_data, 16'd3);
      checkOutput("bp_valid", 16'(rsp_valid), 16'd1);
      checkOutput("bp_cmd_ready", 16'(cmd_ready), 16'd0);
      @(negedge clk);
    end
    checkOutput("bp_data_end", rsp_data, 16'd3);
    finishResponse("bp");

    // Reset asserted while the sequencer is waiting on the ALU.
    applyStimulus(16'd5, 16'd2, 4'b0000);
    @(negedge clk);
    checkOutput("mid_wait_busy", 16'(busy), 16'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 16'(rsp_valid), 16'd0);
    checkOutput("mid_rst_busy", 16'(busy), 16'd0);
    checkOutput("mid_rst_ready", 16'(cmd_ready), 16'd0);
    checkOutput("mid_rst_alu_a", alu_a, 16'd0);
    checkOutput("mid_rst_alu_b", alu_b, 16'd0);
    checkOutput("mid_rst_alu_fun", 16'(alu_fun), 16'h0008);
    checkOutput("mid_rst_data", rsp_data, 16'd0);
    @(negedge clk);
    rst   = 1'b1;
    ghost = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) ghost = 1'b1;
    end
    checkOutput("no_ghost_rsp", 16'(ghost), 16'd0);
    checkOutput("mid_rst_ready_back", 16'(cmd_ready), 16'd1);

    runOp("after_rst", 16'd5, 16'd2, 4'b0000, 16'd7, 1'b0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
